// File: rtl/pulse_gen_mc_if.sv
// rtl/pulse_gen_mc_if.sv - control, configuration and pulse-output bundle of the pulse generator
//
// Purpose: groups every non-clock/non-reset signal of pulse_gen_mc.
//   master : stimulus side (drives control and configuration, observes outputs)
//   slave  : generator side (pulse_gen_mc)
// Signals:
//   clr          synchronous clear
//   ena          run enable; low pauses the frame counter
//   trig         start request for single-shot / burst modes (level)
//   mode         00 continuous, 01 single-shot, 10 burst, 11 continuous
//   period_cfg   frame length minus 1
//   burst_cfg    frames per burst (0 behaves as 1)
//   start_cfg    per-channel start offsets, channel i at [i*CNT_W +: CNT_W]
//   width_cfg    per-channel pulse widths, same packing
//   pulse        registered pulse outputs, one per channel
//   frame_start  one-cycle strobe for count==0 while running
//   busy         high while running
//   done         high once a single-shot / burst sequence has finished

interface pulse_gen_mc_if #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic                   clr;
    logic                   ena;
    logic                   trig;
    logic [1:0]             mode;
    logic [CNT_W-1:0]       period_cfg;
    logic [BURST_W-1:0]     burst_cfg;
    logic [NCH*CNT_W-1:0]   start_cfg;
    logic [NCH*CNT_W-1:0]   width_cfg;
    logic [NCH-1:0]         pulse;
    logic                   frame_start;
    logic                   busy;
    logic                   done;

    modport master (
        output clr, ena, trig, mode, period_cfg, burst_cfg, start_cfg, width_cfg,
        input  pulse, frame_start, busy, done
    );

    modport slave (
        input  clr, ena, trig, mode, period_cfg, burst_cfg, start_cfg, width_cfg,
        output pulse, frame_start, busy, done
    );
endinterface

// File: rtl/pulse_gen_mc.sv
// rtl/pulse_gen_mc.sv - multi-channel programmable test-pulse generator on a shared frame counter
//
// Purpose: one frame counter (0..period) drives NCH pulse channels, each high
//   for count in [start, start+width). Continuous, single-shot and N-frame
//   burst run modes. Bring-up stimulus only.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   pulse_gen_mc_if.slave: clr/ena/trig/mode + configuration in,
//         pulse/frame_start/busy/done out (all outputs registered)

module pulse_gen_mc #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    pulse_gen_mc_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [BURST_W-1:0]     frame_cnt;

    // Shadow copies of the configuration; the live inputs only matter at
    // run entry and (for period/start/width) at each frame wrap.
    logic [1:0]             mode_sh;
    logic [CNT_W-1:0]       period_sh;
    logic [BURST_W-1:0]     burst_sh;
    logic [NCH*CNT_W-1:0]   start_sh;
    logic [NCH*CNT_W-1:0]   width_sh;

    logic [NCH-1:0]         pulse_q;
    logic                   frame_start_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   needs_trig;
    logic                   enter_run;
    logic                   run_active;
    logic                   at_wrap;
    logic [BURST_W:0]       frames_done;
    logic [BURST_W:0]       burst_target;
    logic                   last_frame;
    logic [NCH-1:0]         in_window;

    assign needs_trig = (bus.mode == MODE_SINGLE) || (bus.mode == MODE_BURST);

    // From IDLE the live mode decides whether trig is needed; from DONE a
    // restart always needs trig.
    always_comb begin
        enter_run = 1'b0;
        case (state)
            ST_IDLE: enter_run = bus.ena && (!needs_trig || bus.trig);
            ST_DONE: enter_run = bus.ena && bus.trig;
            default: enter_run = 1'b0;
        endcase
    end

    assign run_active = (state == ST_RUN) && bus.ena;
    assign at_wrap    = (count == period_sh);

    // Frame count including the one finishing now; burst 0 behaves as 1.
    assign frames_done  = {1'b0, frame_cnt} + (BURST_W+1)'(1);
    assign burst_target = (burst_sh == '0) ? (BURST_W+1)'(1) : {1'b0, burst_sh};
    assign last_frame   = (mode_sh == MODE_SINGLE) ||
                          ((mode_sh == MODE_BURST) && (frames_done == burst_target));

    // Window compare one bit wider than the counter so start+width never
    // wraps; windows beyond period are cut off because count never gets there.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W:0] lo;
        logic [CNT_W:0] hi;
        assign lo           = {1'b0, start_sh[i*CNT_W +: CNT_W]};
        assign hi           = lo + {1'b0, width_sh[i*CNT_W +: CNT_W]};
        assign in_window[i] = ({1'b0, count} >= lo) && ({1'b0, count} < hi);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            count         <= '0;
            frame_cnt     <= '0;
            mode_sh       <= '0;
            period_sh     <= '0;
            burst_sh      <= '0;
            start_sh      <= '0;
            width_sh      <= '0;
            pulse_q       <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (bus.clr) begin
            state         <= ST_IDLE;
            count         <= '0;
            frame_cnt     <= '0;
            mode_sh       <= '0;
            period_sh     <= '0;
            burst_sh      <= '0;
            start_sh      <= '0;
            width_sh      <= '0;
            pulse_q       <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Outputs reflect the count of the cycle just ending, so the
            // final frame's last pulse still appears in the first DONE cycle.
            pulse_q       <= run_active ? in_window : '0;
            frame_start_q <= run_active && (count == '0);

            if (enter_run) begin
                state     <= ST_RUN;
                mode_sh   <= bus.mode;
                period_sh <= bus.period_cfg;
                burst_sh  <= bus.burst_cfg;
                start_sh  <= bus.start_cfg;
                width_sh  <= bus.width_cfg;
                count     <= '0;
                frame_cnt <= '0;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
            end else if (run_active) begin
                if (at_wrap) begin
                    count     <= '0;
                    frame_cnt <= frame_cnt + BURST_W'(1);
                    // Mode and burst length stay fixed for the whole run.
                    period_sh <= bus.period_cfg;
                    start_sh  <= bus.start_cfg;
                    width_sh  <= bus.width_cfg;
                    if (last_frame) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pulse       = pulse_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb/tb_pulse_gen_mc.sv - self-checking bench for pulse_gen_mc against a frame-level reference model

module tb_pulse_gen_mc;

    localparam int NCH     = 4;
    localparam int CNT_W   = 8;
    localparam int BURST_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pulse_gen_mc_if #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    pulse_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase 0 stopped, 1 running, 2 finished.
    int phase = 0, cnt = 0, frames = 0;
    int m_mode = 0, m_per = 0, m_burst = 0;
    int m_start [NCH];
    int m_width [NCH];
    logic [NCH-1:0] e_pulse = '0;
    logic e_fs = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    // Observation counters.
    int fs_total = 0;
    int p_total [NCH];
    int cyc = 0, last_fs = 0, fs_gap = 0;
    int prints = 0;

    function automatic int fld(logic [NCH*CNT_W-1:0] v, int i);
        return int'(v[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_zero();
        phase = 0; cnt = 0; frames = 0;
        m_mode = 0; m_per = 0; m_burst = 0;
        for (int i = 0; i < NCH; i++) begin
            m_start[i] = 0;
            m_width[i] = 0;
        end
        e_pulse = '0; e_fs = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_latch();
        m_mode  = int'(bus.mode);
        m_per   = int'(bus.period_cfg);
        m_burst = int'(bus.burst_cfg);
        for (int i = 0; i < NCH; i++) begin
            m_start[i] = fld(bus.start_cfg, i);
            m_width[i] = fld(bus.width_cfg, i);
        end
        cnt = 0; frames = 0; phase = 1;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_start[i] = 0; m_width[i] = 0; p_total[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || bus.clr) begin
                model_zero();
            end else begin
                for (int i = 0; i < NCH; i++)
                    e_pulse[i] = (phase == 1) && bus.ena &&
                                 (cnt >= m_start[i]) && (cnt < m_start[i] + m_width[i]);
                e_fs = (phase == 1) && bus.ena && (cnt == 0);
                if (phase == 0 && bus.ena &&
                    (((bus.mode == 2'd1) || (bus.mode == 2'd2)) ? bus.trig : 1'b1)) begin
                    model_latch();
                end else if (phase == 2 && bus.ena && bus.trig) begin
                    model_latch();
                end else if (phase == 1 && bus.ena) begin
                    if (cnt == m_per) begin
                        frames = frames + 1;
                        cnt = 0;
                        m_per = int'(bus.period_cfg);
                        for (int i = 0; i < NCH; i++) begin
                            m_start[i] = fld(bus.start_cfg, i);
                            m_width[i] = fld(bus.width_cfg, i);
                        end
                        if (m_mode == 1 || (m_mode == 2 && frames == ((m_burst == 0) ? 1 : m_burst)))
                            phase = 2;
                        frames = frames % (1 << BURST_W);
                    end else begin
                        cnt = cnt + 1;
                    end
                end
                e_busy = (phase == 1);
                e_done = (phase == 2);
            end
        end
    end

    // Per-cycle compare against the model, plus observation counters.
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst) begin
                vectors = vectors + 1;
                if (bus.pulse !== e_pulse || bus.frame_start !== e_fs ||
                    bus.busy !== e_busy || bus.done !== e_done) begin
                    miscompares = miscompares + 1;
                    if (prints < 30) begin
                        prints = prints + 1;
                        $display("FAIL cycle_%0d: pulse=%b fs=%b busy=%b done=%b, required pulse=%b fs=%b busy=%b done=%b",
                                 cyc, bus.pulse, bus.frame_start, bus.busy, bus.done,
                                 e_pulse, e_fs, e_busy, e_done);
                    end
                end
                if (bus.frame_start === 1'b1) begin
                    fs_total = fs_total + 1;
                    fs_gap   = cyc - last_fs;
                    last_fs  = cyc;
                end
                for (int i = 0; i < NCH; i++)
                    if (bus.pulse[i] === 1'b1) p_total[i] = p_total[i] + 1;
            end
        end
    end

    task automatic chk(string name, int act, int req);
        vectors = vectors + 1;
        if (act != req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ch(int i, int s, int w);
        bus.start_cfg[i*CNT_W +: CNT_W] = CNT_W'(s);
        bus.width_cfg[i*CNT_W +: CNT_W] = CNT_W'(w);
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic wait_fs(string name, int target, int budget);
        int n = 0;
        while (fs_total < target && n < budget) begin
            tick();
            n++;
        end
        if (fs_total < target) chk(name, fs_total, target);
    endtask

    int s_fs;
    int s_p [NCH];

    task automatic snap();
        s_fs = fs_total;
        for (int i = 0; i < NCH; i++) s_p[i] = p_total[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr = 1'b0; bus.ena = 1'b0; bus.trig = 1'b0; bus.mode = 2'd0;
        bus.period_cfg = '0; bus.burst_cfg = '0; bus.start_cfg = '0; bus.width_cfg = '0;
        repeat (3) tick();
        chk("reset_pulse", int'(bus.pulse), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        rst = 1'b1;
        tick();

        // Continuous, 100 frames; ch2 width 0 and ch3 start > period stay silent.
        bus.mode = 2'd0; bus.period_cfg = 8'd19;
        set_ch(0, 5, 3); set_ch(1, 0, 20); set_ch(2, 3, 0); set_ch(3, 25, 4);
        snap();
        bus.ena = 1'b1;
        repeat (2001) tick();
        chk("cont_frames", fs_total - s_fs, 100);
        chk("cont_ch0", p_total[0] - s_p[0], 300);
        chk("cont_ch1", p_total[1] - s_p[1], 2000);
        chk("cont_width0", p_total[2] - s_p[2], 0);
        chk("cont_start_gt_period", p_total[3] - s_p[3], 0);

        // Single-shot, twice.
        bus.ena = 1'b0; do_clr();
        bus.mode = 2'd1; bus.period_cfg = 8'd9; set_ch(0, 2, 2);
        for (int k = 0; k < 2; k++) begin
            snap();
            bus.ena = 1'b1; bus.trig = 1'b1; tick(); bus.trig = 1'b0;
            repeat (20) tick();
            chk("single_frames", fs_total - s_fs, 1);
            chk("single_ch0", p_total[0] - s_p[0], 2);
            chk("single_ch1_trunc", p_total[1] - s_p[1], 10);
            chk("single_done", int'(bus.done), 1);
            chk("single_busy", int'(bus.busy), 0);
        end

        // Burst of 3, then burst_cfg 0 behaving as 1.
        do_clr();
        bus.mode = 2'd2; bus.burst_cfg = 4'd3; bus.period_cfg = 8'd4; set_ch(0, 1, 2);
        snap();
        bus.trig = 1'b1; tick(); bus.trig = 1'b0;
        repeat (30) tick();
        chk("burst3_frames", fs_total - s_fs, 3);
        chk("burst3_ch0", p_total[0] - s_p[0], 6);
        chk("burst3_ch1", p_total[1] - s_p[1], 15);
        chk("burst3_done", int'(bus.done), 1);
        do_clr();
        bus.burst_cfg = 4'd0;
        snap();
        bus.trig = 1'b1; tick(); bus.trig = 1'b0;
        repeat (30) tick();
        chk("burst0_frames", fs_total - s_fs, 1);
        chk("burst0_ch0", p_total[0] - s_p[0], 2);

        // Pause mid-window for 5 cycles.
        bus.ena = 1'b0; do_clr();
        bus.mode = 2'd0; bus.period_cfg = 8'd19; set_ch(0, 5, 8);
        snap();
        bus.ena = 1'b1;
        wait_fs("pause_fs1_timeout", s_fs + 1, 40);
        repeat (7) tick();
        bus.ena = 1'b0;
        repeat (5) tick();
        bus.ena = 1'b1;
        wait_fs("pause_fs2_timeout", s_fs + 2, 60);
        chk("pause_frame_len", fs_gap, 25);
        chk("pause_ch0_total", p_total[0] - s_p[0], 8);

        // Period change mid-frame takes effect at the next wrap; then clr mid-run.
        bus.ena = 1'b0; do_clr();
        snap();
        bus.ena = 1'b1;
        wait_fs("per_fs1_timeout", s_fs + 1, 40);
        repeat (10) tick();
        bus.period_cfg = 8'd9;
        wait_fs("per_fs2_timeout", s_fs + 2, 40);
        chk("per_old_len", fs_gap, 20);
        wait_fs("per_fs3_timeout", s_fs + 3, 40);
        chk("per_new_len", fs_gap, 10);
        bus.clr = 1'b1; tick();
        chk("clr_pulse", int'(bus.pulse), 0);
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_fs", int'(bus.frame_start), 0);
        bus.clr = 1'b0;

        // period 0: one-cycle frames.
        bus.ena = 1'b0; do_clr();
        bus.period_cfg = 8'd0; set_ch(0, 0, 1); set_ch(1, 1, 1);
        snap();
        bus.ena = 1'b1;
        repeat (11) tick();
        chk("p0_frames", fs_total - s_fs, 10);
        chk("p0_ch0", p_total[0] - s_p[0], 10);
        chk("p0_ch1", p_total[1] - s_p[1], 0);

        // Window start+width beyond the counter range is truncated, not wrapped.
        bus.ena = 1'b0; do_clr();
        bus.period_cfg = 8'd255; set_ch(0, 250, 20);
        snap();
        bus.ena = 1'b1;
        repeat (257) tick();
        chk("wide_frames", fs_total - s_fs, 1);
        chk("wide_ch0", p_total[0] - s_p[0], 6);

        // Asynchronous reset between clock edges in the middle of a burst.
        bus.ena = 1'b0; do_clr();
        bus.mode = 2'd2; bus.burst_cfg = 4'd5; bus.period_cfg = 8'd30; set_ch(1, 0, 31);
        bus.ena = 1'b1; bus.trig = 1'b1; tick(); bus.trig = 1'b0;
        repeat (10) tick();
        chk("pre_arst_ch1", int'(bus.pulse[1]), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_pulse", int'(bus.pulse), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_fs", int'(bus.frame_start), 0);
        tick();
        rst = 1'b1;
        tick();

        // Randomized configurations and control.
        for (int r = 0; r < 40; r++) begin
            do_clr();
            bus.mode       = 2'($urandom_range(0, 3));
            bus.period_cfg = CNT_W'($urandom_range(0, 15));
            bus.burst_cfg  = BURST_W'($urandom_range(0, 3));
            for (int i = 0; i < NCH; i++)
                set_ch(i, int'($urandom_range(0, 18)), int'($urandom_range(0, 18)));
            repeat (150) begin
                bus.ena  = ($urandom_range(0, 9) != 0);
                bus.trig = ($urandom_range(0, 7) == 0);
                bus.clr  = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 19) == 0) bus.period_cfg = CNT_W'($urandom_range(0, 15));
                if ($urandom_range(0, 29) == 0)
                    set_ch(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 18)),
                           int'($urandom_range(0, 18)));
                tick();
            end
            bus.clr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_gen_mc.md
Name: pulse_gen_mc

Overview:
Parametrised multi-channel test-pulse generator, the next generation of the single-counter two-pulse test source. One shared frame counter drives NCH independent pulse channels, each with its own programmable start offset and width. The frame period and run mode are also programmable: continuous, single-shot or N-frame burst. This is test-bench/bring-up stimulus for the sig_acq acquisition path and is not part of the final design.

Parameters:
NCH, 4, number of pulse channels (1..16)
CNT_W, 16, frame counter width; frame length up to 2^CNT_W cycles
BURST_W, 8, burst frame-count width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; highest priority after rst
ena  in  1  run enable; low pauses the frame counter
trig  in  1  start request for single-shot/burst modes (level, sampled per cycle)
mode  in  2  00 continuous, 01 single-shot, 10 burst, 11 reserved (treated as 00)
period_cfg  in  CNT_W  frame length minus 1
burst_cfg  in  BURST_W  frames per burst; 0 treated as 1
start_cfg  in  NCH*CNT_W  per-channel start offset, channel i at [i*CNT_W +: CNT_W]
width_cfg  in  NCH*CNT_W  per-channel pulse width in cycles, packed the same way
pulse  out  NCH  registered pulse outputs
frame_start  out  1  one-cycle strobe when count==0 in RUN
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset (rst=0, async): state IDLE; count, frame_cnt and shadow registers are 0; pulse, frame_start, busy and done are 0.
- clr=1 (sync): same values as reset on the next edge, regardless of state.
- States are IDLE, RUN and DONE.
- IDLE->RUN:
  - mode 00/11: when ena=1.
  - mode 01/10: when ena=1 and trig=1.
  - On this transition, mode, period_cfg, burst_cfg, start_cfg and width_cfg are latched into shadow registers; count=0 and frame_cnt=0.
- RUN:
  - ena=1: count increments. When count==shadow period, count wraps to 0, frame_cnt increments, and period/start/width shadows reload from the inputs. Mode does not reload mid-run.
  - ena=0: count and frame_cnt hold; pulse is forced to 0 from the next cycle; frame_start=0.
  - trig is ignored.
- RUN exit conditions (evaluated at wrap):
  - single-shot: after the first frame, to DONE.
  - burst: when frame_cnt+1 == max(burst_cfg_shadow, 1), to DONE.
  - continuous: never exits; return to IDLE only via clr.
- DONE: done=1, pulse=0. trig=1 with ena=1 re-enters RUN with a fresh shadow latch. clr goes to IDLE.
- Pulse rule, per channel i, registered with 1-cycle latency: pulse[i] at cycle t+1 = (RUN && ena && start_i <= count(t) < start_i + width_i).
  - The comparison is in CNT_W+1 bits, so there is no wrap.
  - width 0 means the channel never fires.
  - start > period means it never fires.
  - A window extending past period is truncated at the frame end.
- frame_start is registered like pulse: asserted one cycle after count==0 while RUN && ena.
- busy and done are registered state decodes, valid the cycle after the transition.
- Terminal frame: the last pulses of the final frame still appear (1-cycle latency), then pulse=0 in DONE.
- period_cfg=0 gives a 1-cycle frame: count stays 0 and frame_start is high every enabled cycle.
- Changing config mid-frame has no effect until the next wrap.

Test Plan:
- mode=00, period=19, ch0 start=5 width=3, ch1 start=0 width=20, ena=1 -> ch0 high for cycles 6..8 after each frame_start-aligned count 0 (1-cycle latency); ch1 constantly high; frame_start every 20 cycles.
- mode=01, period=9, ch0 start=2 width=2, trig pulse -> exactly one ch0 pulse of 2 cycles; done=1 and busy=0 from the cycle after the wrap; a second trig produces one more pulse.
- mode=10, burst_cfg=3, period=4 -> exactly 3 frame_start strobes and 3 ch pulses, then DONE; repeat with burst_cfg=0 -> 1 frame.
- ena toggled low for 5 cycles mid-window -> pulse drops within 1 cycle, count holds, the pulse resumes with its remaining width on re-enable; total frame length is extended by exactly 5.
- Change period_cfg from 19 to 9 at count=10 -> the current frame completes at 19 and the next frame is 10 cycles; clr mid-RUN -> all outputs 0 next cycle, state IDLE.
- Async rst asserted mid-burst between clock edges -> outputs 0 immediately; width=0 and start>period channels never assert across 100 frames.
